// File: rtl/mem_req_queue.sv
// Per-port request FIFOs feeding a round-robin arbiter; a registered one-hot gnt pops the head entry.
// Latency: 1 cycle from gnt to mem access. in_ready drops when a port is full. There is no stall path on the mem side.
module mem_req_queue #(
    parameter int Req_Width  = 5,
    parameter int Addr_Width = 10,
    parameter int Data_Width = 32,
    parameter int Fifo_Depth = 4,
    localparam int Port_Width = (Req_Width > 1) ? $clog2(Req_Width) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [Req_Width-1:0]             in_valid,
    output logic [Req_Width-1:0]             in_ready,
    input  logic [Req_Width-1:0]             in_we,
    input  logic [Req_Width*Addr_Width-1:0]  in_addr,
    input  logic [Req_Width*Data_Width-1:0]  in_wdata,
    output logic [Req_Width-1:0]             req,
    input  logic [Req_Width-1:0]             gnt,
    output logic                             mem_valid,
    output logic                             mem_we,
    output logic [Addr_Width-1:0]            mem_addr,
    output logic [Data_Width-1:0]            mem_wdata,
    output logic [Port_Width-1:0]            mem_port,
    output logic                             err_gnt
);

    localparam int PtrW = $clog2(Fifo_Depth);
    localparam int CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(Fifo_Depth);

    typedef struct packed {
        logic                  we;
        logic [Addr_Width-1:0] addr;
        logic [Data_Width-1:0] wdata;
    } entry_t;

    entry_t          store  [Req_Width][Fifo_Depth];
    logic [PtrW-1:0] wr_ptr [Req_Width];
    logic [PtrW-1:0] rd_ptr [Req_Width];
    logic [CntW-1:0] count  [Req_Width];

    logic [Req_Width-1:0]  push;
    logic [Req_Width-1:0]  pop;
    logic [Req_Width-1:0]  empty;
    logic                  gnt_multi;
    logic                  gnt_bad;
    logic                  pop_any;
    logic [Port_Width-1:0] pop_idx;
    entry_t                pop_entry;

    assign gnt_multi = (gnt & (gnt - Req_Width'(1))) != '0;
    assign gnt_bad   = gnt_multi | (|(gnt & empty));
    assign pop_any   = |pop;

    // req compares against the incoming grant so a port whose last entry is being granted drops req in the same cycle.
    always_comb begin
        empty    = '0;
        in_ready = '0;
        req      = '0;
        push     = '0;
        pop      = '0;
        for (int i = 0; i < Req_Width; i++) begin
            empty[i]    = (count[i] == '0);
            in_ready[i] = (count[i] != Full);
            req[i]      = (count[i] > {{(CntW-1){1'b0}}, gnt[i]});
            push[i]     = in_valid[i] & in_ready[i];
            pop[i]      = gnt[i] & ~gnt_multi & ~empty[i];
        end
    end

    always_comb begin
        pop_idx   = '0;
        pop_entry = '0;
        for (int i = 0; i < Req_Width; i++) begin
            if (pop[i]) begin
                pop_idx   = Port_Width'(i);
                pop_entry = store[i][rd_ptr[i]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Req_Width; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < Req_Width; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PtrW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PtrW'(1);
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CntW'(1);
                    2'b01:   count[i] <= count[i] - CntW'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Entry storage needs no reset: the pointers and counts alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < Req_Width; i++) begin
            if (push[i]) begin
                store[i][wr_ptr[i]] <= {in_we[i],
                                        in_addr[i*Addr_Width +: Addr_Width],
                                        in_wdata[i*Data_Width +: Data_Width]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_port  <= '0;
            err_gnt   <= 1'b0;
        end else begin
            mem_valid <= pop_any;
            err_gnt   <= err_gnt | gnt_bad;
            if (pop_any) begin
                mem_we    <= pop_entry.we;
                mem_addr  <= pop_entry.addr;
                mem_wdata <= pop_entry.wdata;
                mem_port  <= pop_idx;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed and random stimulus for mem_req_queue, compared against a queue-based reference model.
module tb_mem_req_queue;

    localparam int RW = 5;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int FD = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [RW-1:0]     in_valid;
    logic [RW-1:0]     in_ready;
    logic [RW-1:0]     in_we;
    logic [RW*AW-1:0]  in_addr;
    logic [RW*DW-1:0]  in_wdata;
    logic [RW-1:0]     req;
    logic [RW-1:0]     gnt;
    logic              mem_valid;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [2:0]        mem_port;
    logic              err_gnt;

    always #5 clk = ~clk;

    mem_req_queue #(.Req_Width(RW), .Addr_Width(AW), .Data_Width(DW), .Fifo_Depth(FD)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .req(req), .gnt(gnt),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_port(mem_port), .err_gnt(err_gnt)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } ent_t;

    ent_t          q [RW][$];
    logic          e_valid, e_we, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [2:0]    e_port;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [RW-1:0] x_ready, x_req;
        for (int i = 0; i < RW; i++) begin
            x_ready[i] = (q[i].size() != FD);
            x_req[i]   = (q[i].size() > int'(gnt[i]));
        end
        check("in_ready",  64'(in_ready),  64'(x_ready));
        check("req",       64'(req),       64'(x_req));
        check("mem_valid", 64'(mem_valid), 64'(e_valid));
        check("mem_we",    64'(mem_we),    64'(e_we));
        check("mem_addr",  64'(mem_addr),  64'(e_addr));
        check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
        check("mem_port",  64'(mem_port),  64'(e_port));
        check("err_gnt",   64'(err_gnt),   64'(e_err));
    endtask

    // Reference: one queue per port; a legal grant pops the front, a bad grant sets the sticky error.
    task automatic model_edge();
        logic [RW-1:0] push_ok;
        ent_t          e;
        int            ones;
        ones = $countones(gnt);
        for (int i = 0; i < RW; i++) push_ok[i] = in_valid[i] && (q[i].size() < FD);
        e_valid = 1'b0;
        if (ones > 1) begin
            e_err = 1'b1;
        end else if (ones == 1) begin
            for (int i = 0; i < RW; i++) begin
                if (gnt[i]) begin
                    if (q[i].size() > 0) begin
                        e       = q[i].pop_front();
                        e_valid = 1'b1;
                        e_we    = e.we;
                        e_addr  = e.addr;
                        e_wdata = e.wdata;
                        e_port  = 3'(i);
                    end else begin
                        e_err = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < RW; i++) begin
            if (push_ok[i]) q[i].push_back({in_we[i], in_addr[i*AW +: AW], in_wdata[i*DW +: DW]});
        end
    endtask

    // Inputs are set at the falling edge; outputs are checked 1 time unit later, before the rising edge.
    task automatic step();
        #1;
        check_all();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = '0;
        gnt      = '0;
    endtask

    task automatic set_port(input int p, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        in_valid[p]            = 1'b1;
        in_we[p]               = we;
        in_addr[p*AW +: AW]    = addr;
        in_wdata[p*DW +: DW]   = wdata;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        for (int i = 0; i < RW; i++) q[i].delete();
        e_valid = 1'b0; e_we = 1'b0; e_err = 1'b0;
        e_addr  = '0;   e_wdata = '0; e_port = '0;
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int cand[$];
        int r;
        idle();
        in_we = '0; in_addr = '0; in_wdata = '0;
        @(negedge clk);
        do_reset();

        // Reset then idle
        idle(); step(); step();

        // Single push on port 2, then grant it
        set_port(2, 1'b1, 10'h005, 32'hA5A5A5A5); step();
        idle(); gnt = 5'b00100; step();
        idle(); step();
        check("dir_port2", 64'({mem_port, mem_addr, mem_wdata}), 64'({3'd2, 10'h005, 32'hA5A5A5A5}));
        step();

        // Fill port 0, push+grant while full, then drain in order
        for (int k = 0; k < 4; k++) begin
            idle(); set_port(0, k[0], 10'(16 + k), 32'h1000_0000 + k); step();
        end
        idle(); set_port(0, 1'b1, 10'h3FF, 32'hDEADBEEF); gnt = 5'b00001; step();
        for (int k = 0; k < 5; k++) begin
            idle(); gnt = 5'b00001; step();
        end
        idle(); step();

        // Ports 1 and 3 two entries each, alternating grants
        for (int k = 0; k < 2; k++) begin
            idle();
            set_port(1, 1'b0, 10'(32 + k), 32'h1111_0000 + k);
            set_port(3, 1'b1, 10'(48 + k), 32'h3333_0000 + k);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            idle(); gnt = k[0] ? 5'b01000 : 5'b00010; step();
        end
        idle(); step();

        // Protocol errors: grant to empty port, then multi-hot grant
        idle(); gnt = 5'b10000; step();
        idle(); step();
        idle(); set_port(0, 1'b1, 10'h0AA, 32'h0); set_port(1, 1'b0, 10'h0BB, 32'h1); step();
        idle(); gnt = 5'b00011; step();
        idle(); step();
        check("dir_err_sticky", 64'(err_gnt), 64'(1));

        // Asynchronous reset in the middle of a grant cycle
        do_reset();
        for (int k = 0; k < 3; k++) begin
            idle(); set_port(1, 1'b1, 10'(64 + k), 32'h5555_0000 + k); step();
        end
        idle(); gnt = 5'b00010;
        #2;
        do_reset();
        idle(); step(); step();

        // Random traffic: arbiter-like legal grants, with illegal grants only near the end
        do_reset();
        for (int n = 0; n < 600; n++) begin
            in_valid = RW'($urandom);
            in_we    = RW'($urandom);
            for (int p = 0; p < RW; p++) begin
                in_addr[p*AW +: AW]  = AW'($urandom);
                in_wdata[p*DW +: DW] = $urandom;
            end
            gnt = '0;
            r = int'($urandom_range(0, 9));
            if (r < 7) begin
                cand.delete();
                for (int p = 0; p < RW; p++) if (q[p].size() > 0) cand.push_back(p);
                if (cand.size() > 0) gnt = RW'(1) << cand[$urandom_range(0, cand.size() - 1)];
            end else if (r == 9 && n >= 500) begin
                gnt = RW'($urandom);
            end
            step();
        end
        idle(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
